// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq: two-requester round-robin front end for a priority
// right-shift unit. Result W = D >> k, k = index of lowest set bit of N,
// W = 0 when N = 0. The shift runs serially, one bit per cycle, on a single
// shared register.
// Optional macro SHIFT_FASTPATH_EN: load D >> k in one step on acceptance and
// go straight to RESP (fixed latency of one cycle).
module shift_arbiter_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_d,
  input  logic [WIDTH-1:0] req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_d,
  input  logic [WIDTH-1:0] req1_n,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_w,
  output logic             resp_id,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_id;
  // Requester preferred on a tie; 0 after reset, i.e. last grant was 1.
  logic             r_rr_ptr;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_d;
  logic [WIDTH-1:0] w_sel_n;
  logic [CNT_W-1:0] w_k;
  logic             w_nz;

  // Index of the lowest set mask bit; 0 for an empty mask.
  function automatic logic [CNT_W-1:0] f_lsb_idx(input logic [WIDTH-1:0] n);
    logic [CNT_W-1:0] k;
    k = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (n[i]) k = CNT_W'(i);
    end
    return k;
  endfunction

  assign w_idle = (r_state == IDLE);

  // Round-robin grant: a lone requester wins, ties go to the preferred one.
  always_comb begin
    w_grant = r_rr_ptr;
    if (req0_valid && !req1_valid)      w_grant = 1'b0;
    else if (!req0_valid && req1_valid) w_grant = 1'b1;
  end

  assign req0_ready = rst_n & w_idle & req0_valid & ~w_grant;
  assign req1_ready = rst_n & w_idle & req1_valid &  w_grant;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_d = w_grant ? req1_d : req0_d;
  assign w_sel_n = w_grant ? req1_n : req0_n;
  assign w_k     = f_lsb_idx(w_sel_n);
  assign w_nz    = |w_sel_n;

  // Next-state logic for the IDLE -> SHIFT -> RESP sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef SHIFT_FASTPATH_EN
          w_next = RESP;
`else
          w_next = (w_k != '0) ? SHIFT : RESP;
`endif
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) w_next = RESP;
      end
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operand load on acceptance, then one zero-fill right shift per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_id     <= 1'b0;
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_id     <= w_grant;
      r_rr_ptr <= ~w_grant;
`ifdef SHIFT_FASTPATH_EN
      r_shift  <= w_nz ? (w_sel_d >> w_k) : '0;
      r_cnt    <= '0;
`else
      r_shift  <= w_nz ? w_sel_d : '0;
      r_cnt    <= w_k;
`endif
    end else if (r_state == SHIFT) begin
      r_shift  <= r_shift >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_w     = r_shift;
  assign resp_id    = r_id;
  assign busy       = ~w_idle;

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Directed testbench for shift_arbiter_seq: a vector table of operations with
// hand-computed results, plus reset and reset-mid-operation sequences.
module tb_shift_arbiter_seq;

  localparam int WIDTH = 16;
`ifdef SHIFT_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_d;
  logic [WIDTH-1:0] req0_n;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_d;
  logic [WIDTH-1:0] req1_n;
  logic             req1_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_w;
  logic             resp_id;
  logic             resp_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             v0;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] n0;
    logic             v1;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] n1;
    logic             id;
    logic [WIDTH-1:0] w;
    int               k;
  } vec_t;

  vec_t tbl [8];

  shift_arbiter_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_d     (req0_d),
    .req0_n     (req0_n),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_d     (req1_d),
    .req1_n     (req1_n),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_w     (resp_w),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int guard;
    int lat;
    req0_valid = v.v0; req0_d = v.d0; req0_n = v.n0;
    req1_valid = v.v1; req1_d = v.d1; req1_n = v.n1;
    resp_ready = 1'b0;
    #1;
    guard = 0;
    while (!(req0_ready || req1_ready) && guard < 20) begin
      step();
      guard++;
    end
    chk("grant_ready0", 32'(req0_ready), 32'(v.id == 1'b0));
    chk("grant_ready1", 32'(req1_ready), 32'(v.id == 1'b1));
    step();
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), FAST ? 32'd1 : 32'(v.k + 1));
    chk("resp_w", 32'(resp_w), 32'(v.w));
    chk("resp_id", 32'(resp_id), 32'(v.id));
    for (int i = 0; i < 3; i++) begin
      chk("ready_while_resp", 32'(req0_ready | req1_ready), 32'd0);
      step();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_w", 32'(resp_w), 32'(v.w));
      chk("hold_id", 32'(resp_id), 32'(v.id));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    //             v0    d0        n0        v1    d1        n1        id    w         k
    tbl[0] = '{1'b1, 16'hF0F0, 16'h0010, 1'b1, 16'h1234, 16'h0001, 1'b0, 16'h0F0F, 4};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0001, 1'b1, 16'h1234, 0};
    tbl[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 0};
    tbl[3] = '{1'b1, 16'h8000, 16'h8008, 1'b1, 16'h00FF, 16'h0002, 1'b0, 16'h1000, 3};
    tbl[4] = '{1'b1, 16'h8000, 16'h8008, 1'b1, 16'h00FF, 16'h0002, 1'b1, 16'h007F, 1};
    tbl[5] = '{1'b1, 16'h8000, 16'h8008, 1'b1, 16'h00FF, 16'h0002, 1'b0, 16'h1000, 3};
    tbl[6] = '{1'b1, 16'hABCD, 16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 15};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'hFF00, 1'b1, 16'h0080, 8};

    // Reset held for two cycles with both requesters valid.
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_d = 16'hF0F0; req0_n = 16'h0010;
    req1_valid = 1'b1; req1_d = 16'h1234; req1_n = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_w", 32'(resp_w), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset in the middle of a long operation.
    req0_valid = 1'b1; req0_d = 16'hFFFF; req0_n = 16'h4000;
    req1_valid = 1'b0;
    #1;
    chk("midrst_ready0", 32'(req0_ready), 32'd1);
    step();
    step();
    step();
    step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_w", 32'(resp_w), 32'd0);
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (resp_valid) seen = 1'b1;
    end
    resp_ready = 1'b0;
    chk("midrst_no_resp", 32'(seen), 32'd0);

    // Tie right after reset goes to requester 0 again.
    run_vec(tbl[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter_seq.md
Name: shift_arbiter_seq

Overview:
- Two-requester controller for the priority right-shift datapath. Each request carries data D and mask N. The result is W = D >> k, where k is the index of the lowest set bit of N, and W = 0 when N = 0.
- The block arbitrates round-robin between the two requesters and runs the shift serially, one bit position per cycle, on a single shared shift register.
- It sits between the operand sources and downstream consumers, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, data and mask width.
- CNT_W, $clog2(WIDTH), width of the shift counter. Holds values 0..WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_d  input  WIDTH  requester 0 data
- req0_n  input  WIDTH  requester 0 shift mask
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has an operation
- req1_d  input  WIDTH  requester 1 data
- req1_n  input  WIDTH  requester 1 shift mask
- req1_ready  output  1  requester 1 accepted this cycle
- resp_valid  output  1  result available
- resp_w  output  WIDTH  shifted result
- resp_id  output  1  index of the requester that owns the result
- resp_ready  input  1  consumer accepts result
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- States: IDLE, SHIFT, RESP. One operation is in flight at a time.
- Reset (rst_n = 0 at a clock edge, also mid-operation):
  - state goes to IDLE and the in-flight operation is discarded.
  - Shift register, counter, resp_w, resp_id and the last-grant pointer go to 0.
  - resp_valid, busy, req0_ready and req1_ready are 0 in the cycle after the reset edge.
- Ready outputs: combinational, asserted only in IDLE, and only for the granted requester. At most one ready is high per cycle.
- Arbitration in IDLE:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester other than last_grant. After reset last_grant = 1, so req0 wins the first tie.
  - last_grant updates on acceptance.
- Acceptance cycle t (valid & ready):
  - Load the shift register with the granted d and the counter with k = lowest-set-bit index of n.
  - If n = 0, load the shift register with 0 and k = 0.
  - Latch resp_id.
  - Next state: SHIFT if k > 0, otherwise RESP.
- SHIFT:
  - Each cycle: shift register >>= 1 with zero fill, counter decrements.
  - When the counter equals 1 at a clock edge, perform the final shift and go to RESP.
  - SHIFT therefore lasts exactly k cycles.
- RESP:
  - resp_valid = 1, resp_w = shift register, resp_id = latched id.
  - These outputs hold stable until resp_ready = 1 at a clock edge, then the state returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake. The earliest next acceptance is the following cycle.
- Latency: resp_valid first asserts in cycle t+1+k.
- Requests arriving while busy are ignored and their ready stays low. Requesters must hold valid and operands stable until ready.
- Mask bits above the lowest set bit have no effect.
- WIDTH-1 shifts is the maximum (N = 0x8000 → result D[15]).

Optional Feature:
- Macro SHIFT_FASTPATH_EN.
- Defined:
  - On acceptance the shift register loads d >> k directly (priority barrel shift, 0 when n = 0).
  - The FSM always goes straight to RESP and SHIFT is unused.
  - Latency is fixed at t+1 regardless of k.
  - Arbitration, handshakes and reset are unchanged.
- Undefined: serial behaviour as described above.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with both requesters valid → both readys 0, resp_valid 0, busy 0. After release, req0 is granted first.
- Serial shift: req0 with D = 0xF0F0, N = 0x0010 accepted at t → resp_valid at t+5 with resp_w = 0x0F0F, resp_id = 0. With SHIFT_FASTPATH_EN, the same values appear at t+1.
- Zero shift and empty mask:
  - req1, D = 0x1234, N = 0x0001 → resp_w = 0x1234 at t+1.
  - Then D = 0xFFFF, N = 0x0000 → resp_w = 0x0000 at t+1, resp_id = 1.
- Round-robin:
  - Both valid: req0 D = 0x8000, N = 0x8008 (k = 3); req1 D = 0x00FF, N = 0x0002 (k = 1).
  - Required: first result 0x1000 with id 0, then 0x007F with id 1.
  - Then both valid again → req0 granted.
- Backpressure and reset mid-operation:
  - Hold resp_ready = 0 for 3 cycles in RESP → resp_w and resp_id stable, both readys 0.
  - Separately, assert rst_n = 0 during SHIFT with D = 0xFFFF, N = 0x4000 → next cycle IDLE, busy 0, resp_valid 0, and no response is ever emitted for that operation.
